com_rx_ctrl: RTL and testbench
==============================

COM_RX_CTRL -- requirements
Module: com_rx_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port rx_fs, input, 1, receiver packet-ready; held high until rx_fd seen.
REQ-004 SHALL have port rx_fd, output, 1, packet-consumed acknowledge to receiver.
REQ-005 SHALL have ports rx_btype and rx_bdata, input, 4 each, received packet type and payload; valid while rx_fs is high.
REQ-006 SHALL have port tx_fs, output, 1, reply-send request to transmitter.
REQ-007 SHALL have port tx_fd, input, 1, transmitter reply-sent flag.
REQ-008 SHALL have port tx_btype, output, 4, reply type: ACK=4'b0001, NAK=4'b0010.
REQ-009 SHALL have ports didx, freq, ddidx, output, 4 each, latched configuration registers.
REQ-010 SHALL have port cfg_upd, output, 1, one-cycle pulse on any register update.
REQ-011 SHALL have port err_cnt, output, 8, NAK reply count.

Function
REQ-012 SHALL implement states IDLE, WAIT, READ, DEC, SEND, SWAIT, DONE.
REQ-013 SHALL move IDLE->WAIT unconditionally, then WAIT->READ when rx_fs=1.
REQ-014 SHALL assert rx_fd combinationally in READ only, capture rx_btype/rx_bdata on READ entry, and go READ->DEC when rx_fs=0.
REQ-015 SHALL, in DEC, decode for one cycle: DIDX(0101)->didx<=bdata, ACK; DPARAM(0110)->freq<=bdata if bdata<=4'h9 and ACK, else keep freq and NAK; DDIDX(0111)->ddidx<=bdata, ACK.
REQ-016 SHALL treat received ACK(0001), NAK(0010), STALL(0011) as no-reply: DEC->DONE.
REQ-017 SHALL answer every other btype, including INIT(0000), with NAK.
REQ-018 SHALL pulse cfg_upd in the DEC cycle that writes a register, including writes of an unchanged value.
REQ-019 SHALL go DEC->SEND on reply, assert tx_fs in SEND only, hold tx_btype stable from SEND entry until DONE, and go SEND->SWAIT when tx_fd=1.
REQ-020 SHALL go SWAIT->DONE when tx_fd=0, and DONE->WAIT unconditionally.
REQ-021 SHALL ignore rx_fs outside WAIT; a new packet stays pending at the receiver until WAIT.
REQ-022 SHALL return undefined state encodings to IDLE next cycle.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, set state=IDLE, rx_fd=0, tx_fs=0, tx_btype=0000, didx=0, freq=0, ddidx=0, cfg_upd=0, err_cnt=0.
REQ-024 SHALL abort any transaction when rst is asserted mid-operation, with no register update and no reply.

Configuration
REQ-025 SHALL, with macro COM_RX_ERRCNT_EN defined, increment err_cnt by 1 on each DEC->SEND with NAK, saturating at 8'hFF.
REQ-026 SHALL, without COM_RX_ERRCNT_EN, tie err_cnt to 8'h00 with no counter logic.

Verification
REQ-027 SHALL verify DIDX with bdata=5: didx=5, cfg_upd one cycle, tx_btype=ACK, tx_fs high until tx_fd.
REQ-028 SHALL verify DPARAM with bdata=3 -> freq=3 and ACK; then DPARAM with bdata=A -> freq stays 3, NAK, err_cnt=1 with the macro.
REQ-029 SHALL verify received ACK, NAK, and STALL each give no tx_fs and a return to WAIT within 3 cycles after rx_fs falls.
REQ-030 SHALL verify btype=1111 gives NAK, and 256 NAKs give err_cnt=FF with no wrap.
REQ-031 SHALL verify rx_fs raised during SEND is not acknowledged until SWAIT->DONE->WAIT, then processed normally.
REQ-032 SHALL verify rst in SEND gives tx_fs=0 next cycle and all outputs at reset values.

Source files
------------

// File: rtl/com_rx_ctrl.sv
// com_rx_ctrl: receive-side packet controller.
// Handshakes a packet in from the receiver (rx_fs/rx_fd), decodes it for one
// cycle, updates the configuration registers, and optionally sends an ACK or
// NAK reply through the transmitter handshake (tx_fs/tx_fd).
// Optional feature: define COM_RX_ERRCNT_EN to build the saturating NAK
// counter on err_cnt; otherwise err_cnt is tied to zero.
module com_rx_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_fs,
    output logic       rx_fd,
    input  logic [3:0] rx_btype,
    input  logic [3:0] rx_bdata,
    output logic       tx_fs,
    input  logic       tx_fd,
    output logic [3:0] tx_btype,
    output logic [3:0] didx,
    output logic [3:0] freq,
    output logic [3:0] ddidx,
    output logic       cfg_upd,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] BT_ACK    = 4'b0001;
    localparam logic [3:0] BT_NAK    = 4'b0010;
    localparam logic [3:0] BT_STALL  = 4'b0011;
    localparam logic [3:0] BT_DIDX   = 4'b0101;
    localparam logic [3:0] BT_DPARAM = 4'b0110;
    localparam logic [3:0] BT_DDIDX  = 4'b0111;
    localparam logic [3:0] FREQ_MAX  = 4'h9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_READ  = 3'd2,
        S_DEC   = 3'd3,
        S_SEND  = 3'd4,
        S_SWAIT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] btype_q;
    logic [3:0] bdata_q;

    logic dec_reply;
    logic dec_nak;
    logic wr_didx;
    logic wr_freq;
    logic wr_ddidx;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic and the two handshake strobes, which are pure state decodes.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned and no latch is inferred.
        state_next = state;
        rx_fd      = 1'b0;
        tx_fs      = 1'b0;
        case (state)
            S_IDLE:  state_next = S_WAIT;
            S_WAIT:  if (rx_fs) state_next = S_READ;
            S_READ: begin
                rx_fd = 1'b1;
                if (!rx_fs) state_next = S_DEC;
            end
            S_DEC:   state_next = dec_reply ? S_SEND : S_DONE;
            S_SEND: begin
                tx_fs = 1'b1;
                if (tx_fd) state_next = S_SWAIT;
            end
            S_SWAIT: if (!tx_fd) state_next = S_DONE;
            S_DONE:  state_next = S_WAIT;
            default: state_next = S_IDLE;
        endcase
    end

    // Packet decode from the captured type/payload; only acted on in DEC.
    always_comb begin
        dec_reply = 1'b1;
        dec_nak   = 1'b1;
        wr_didx   = 1'b0;
        wr_freq   = 1'b0;
        wr_ddidx  = 1'b0;
        case (btype_q)
            BT_DIDX: begin
                wr_didx = 1'b1;
                dec_nak = 1'b0;
            end
            BT_DPARAM: begin
                if (bdata_q <= FREQ_MAX) begin
                    wr_freq = 1'b1;
                    dec_nak = 1'b0;
                end
            end
            BT_DDIDX: begin
                wr_ddidx = 1'b1;
                dec_nak  = 1'b0;
            end
            BT_ACK, BT_NAK, BT_STALL: begin
                dec_reply = 1'b0;
                dec_nak   = 1'b0;
            end
            default: ;
        endcase
    end

    assign cfg_upd = (state == S_DEC) && (wr_didx || wr_freq || wr_ddidx);

    // Capture the packet on READ entry, commit register writes and the reply type out of DEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            btype_q  <= '0;
            bdata_q  <= '0;
            didx     <= '0;
            freq     <= '0;
            ddidx    <= '0;
            tx_btype <= '0;
        end else begin
            if (state == S_WAIT && rx_fs) begin
                btype_q <= rx_btype;
                bdata_q <= rx_bdata;
            end
            if (state == S_DEC) begin
                if (wr_didx)  didx  <= bdata_q;
                if (wr_freq)  freq  <= bdata_q;
                if (wr_ddidx) ddidx <= bdata_q;
                if (dec_reply) tx_btype <= dec_nak ? BT_NAK : BT_ACK;
            end
        end
    end

`ifdef COM_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of NAK replies issued.
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt_q <= '0;
        else if (state == S_DEC && dec_reply && dec_nak && err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_com_rx_ctrl.sv
// tb_com_rx_ctrl: self-checking bench for com_rx_ctrl.
// Expected values come from a transaction-level model: each packet is mapped
// to (reply?, reply type, register written) straight from the packet rules.
module tb_com_rx_ctrl;

    localparam logic [3:0] ACK = 4'b0001;
    localparam logic [3:0] NAK = 4'b0010;
`ifdef COM_RX_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_fs = 1'b0;
    logic       rx_fd;
    logic [3:0] rx_btype = '0;
    logic [3:0] rx_bdata = '0;
    logic       tx_fs;
    logic       tx_fd = 1'b0;
    logic [3:0] tx_btype;
    logic [3:0] didx;
    logic [3:0] freq;
    logic [3:0] ddidx;
    logic       cfg_upd;
    logic [7:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [3:0] m_didx = '0;
    logic [3:0] m_freq = '0;
    logic [3:0] m_ddidx = '0;
    logic [3:0] m_txb = '0;
    int         m_err = 0;

    com_rx_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .rx_fs    (rx_fs),
        .rx_fd    (rx_fd),
        .rx_btype (rx_btype),
        .rx_bdata (rx_bdata),
        .tx_fs    (tx_fs),
        .tx_fd    (tx_fd),
        .tx_btype (tx_btype),
        .didx     (didx),
        .freq     (freq),
        .ddidx    (ddidx),
        .cfg_upd  (cfg_upd),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    // Full packet transaction. Called at a negedge with the DUT in DONE or
    // IDLE (or WAIT); exp_lat>0 checks the negedges until rx_fd. When pend
    // is set a new packet is raised in SEND and must not be acknowledged.
    task automatic send_packet(input logic [3:0] bt, input logic [3:0] bd,
                               input int exp_lat, input int hold,
                               input bit pend, input logic [3:0] pbt,
                               input logic [3:0] pbd);
        int  lat;
        bit  reply;
        bit  upd;
        logic [3:0] rtype;

        reply = !(bt == 4'd1 || bt == 4'd2 || bt == 4'd3);
        upd   = (bt == 4'd5) || (bt == 4'd7) || (bt == 4'd6 && bd <= 4'd9);
        rtype = upd ? ACK : NAK;

        rx_fs = 1'b1; rx_btype = bt; rx_bdata = bd;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rx_fd === 1'b1) break;
        end
        n_tests++;
        if (rx_fd !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_fd_timeout: got rx_fd=%b expected 1 within 20 cycles", rx_fd);
            rx_fs = 1'b0;
            return;
        end
        if (exp_lat > 0) begin
            n_tests++;
            if (lat != exp_lat) begin
                n_fail++;
                $display("FAIL ack_latency bt=%h: got %0d expected %0d cycles", bt, lat, exp_lat);
            end
        end
        // rx_fd stays up while the receiver holds rx_fs.
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            n_tests++;
            if (rx_fd !== 1'b1 || tx_fs !== 1'b0) begin
                n_fail++;
                $display("FAIL read_hold: got rx_fd=%b tx_fs=%b expected 1 0", rx_fd, tx_fs);
            end
        end
        // Scramble bus after drop: the DUT must use the captured values.
        rx_fs = 1'b0; rx_btype = 4'($urandom); rx_bdata = 4'($urandom);
        @(negedge clk); // DEC
        n_tests++;
        if (rx_fd !== 1'b0 || cfg_upd !== upd || tx_fs !== 1'b0) begin
            n_fail++;
            $display("FAIL dec_cycle bt=%h bd=%h: got rx_fd=%b cfg_upd=%b tx_fs=%b expected 0 %b 0",
                     bt, bd, rx_fd, cfg_upd, tx_fs, upd);
        end
        // Model update.
        if (bt == 4'd5) m_didx = bd;
        if (bt == 4'd6 && bd <= 4'd9) m_freq = bd;
        if (bt == 4'd7) m_ddidx = bd;
        if (reply) begin
            m_txb = rtype;
            if (ERRCNT && rtype == NAK && m_err < 255) m_err++;
        end
        @(negedge clk); // SEND or DONE
        n_tests++;
        if (cfg_upd !== 1'b0 || didx !== m_didx || freq !== m_freq || ddidx !== m_ddidx
            || err_cnt !== 8'(m_err)) begin
            n_fail++;
            $display("FAIL regs bt=%h bd=%h: got upd=%b didx=%h freq=%h ddidx=%h err=%h expected 0 %h %h %h %h",
                     bt, bd, cfg_upd, didx, freq, ddidx, err_cnt, m_didx, m_freq, m_ddidx, 8'(m_err));
        end
        n_tests++;
        if (tx_fs !== reply || tx_btype !== m_txb) begin
            n_fail++;
            $display("FAIL reply bt=%h bd=%h: got tx_fs=%b tx_btype=%h expected %b %h",
                     bt, bd, tx_fs, tx_btype, reply, m_txb);
        end
        if (reply) begin
            if (pend) begin
                rx_fs = 1'b1; rx_btype = pbt; rx_bdata = pbd;
            end
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                n_tests++;
                if (tx_fs !== 1'b1 || tx_btype !== m_txb || rx_fd !== 1'b0) begin
                    n_fail++;
                    $display("FAIL send_hold: got tx_fs=%b tx_btype=%h rx_fd=%b expected 1 %h 0",
                             tx_fs, tx_btype, rx_fd, m_txb);
                end
            end
            tx_fd = 1'b1;
            @(negedge clk); // SWAIT
            n_tests++;
            if (tx_fs !== 1'b0 || tx_btype !== m_txb || rx_fd !== 1'b0) begin
                n_fail++;
                $display("FAIL swait: got tx_fs=%b tx_btype=%h rx_fd=%b expected 0 %h 0",
                         tx_fs, tx_btype, rx_fd, m_txb);
            end
            tx_fd = 1'b0;
            @(negedge clk); // DONE
            n_tests++;
            if (tx_fs !== 1'b0 || tx_btype !== m_txb || rx_fd !== 1'b0) begin
                n_fail++;
                $display("FAIL done: got tx_fs=%b tx_btype=%h rx_fd=%b expected 0 %h 0",
                         tx_fs, tx_btype, rx_fd, m_txb);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (rx_fd !== 1'b0 || tx_fs !== 1'b0 || tx_btype !== 4'h0 || didx !== 4'h0
            || freq !== 4'h0 || ddidx !== 4'h0 || cfg_upd !== 1'b0 || err_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values: got rx_fd=%b tx_fs=%b txb=%h didx=%h freq=%h ddidx=%h upd=%b err=%h expected all zero",
                     rx_fd, tx_fs, tx_btype, didx, freq, ddidx, cfg_upd, err_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_didx();
        send_packet(4'b0101, 4'd5, 2, 3, 1'b0, 4'h0, 4'h0);
        send_packet(4'b0101, 4'd5, 2, 0, 1'b0, 4'h0, 4'h0); // unchanged value still pulses
        send_packet(4'b0111, 4'($urandom), 2, 1, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic test_dparam();
        send_packet(4'b0110, 4'h3, 2, 1, 1'b0, 4'h0, 4'h0);
        send_packet(4'b0110, 4'hA, 2, 1, 1'b0, 4'h0, 4'h0);
        send_packet(4'b0110, 4'h9, 2, 0, 1'b0, 4'h0, 4'h0);
        send_packet(4'b0110, 4'hF, 2, 0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic test_no_reply();
        send_packet(4'b0001, 4'($urandom), 2, 0, 1'b0, 4'h0, 4'h0);
        send_packet(4'b0010, 4'($urandom), 2, 0, 1'b0, 4'h0, 4'h0);
        send_packet(4'b0011, 4'($urandom), 2, 0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic test_nak_types();
        send_packet(4'b1111, 4'($urandom), 2, 1, 1'b0, 4'h0, 4'h0);
        send_packet(4'b0000, 4'($urandom), 2, 0, 1'b0, 4'h0, 4'h0);
        send_packet(4'b0100, 4'($urandom), 2, 2, 1'b0, 4'h0, 4'h0);
        send_packet(4'b1000, 4'($urandom), 2, 0, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++)
            send_packet(4'($urandom), 4'($urandom), 2, $urandom_range(0, 3), 1'b0, 4'h0, 4'h0);
    endtask

    task automatic test_err_saturate();
        logic [3:0] bt;
        for (int i = 0; i < 260; i++) begin
            bt = 4'($urandom_range(8, 15));
            send_packet(bt, 4'($urandom), 2, 0, 1'b0, 4'h0, 4'h0);
        end
        n_tests++;
        if (err_cnt !== (ERRCNT ? 8'hFF : 8'h00)) begin
            n_fail++;
            $display("FAIL err_saturate: got %h expected %h", err_cnt, ERRCNT ? 8'hFF : 8'h00);
        end
    endtask

    task automatic test_pending();
        logic [3:0] pbd;
        pbd = 4'($urandom);
        send_packet(4'b1110, 4'h1, 2, 3, 1'b1, 4'b0111, pbd);
        // rx_fs already high in DONE: WAIT next, READ after.
        send_packet(4'b0111, pbd, 2, 1, 1'b0, 4'h0, 4'h0);
    endtask

    task automatic test_reset_mid();
        logic [3:0] bt;
        logic [3:0] bd;
        int lat;
        bt = 4'b0101; bd = 4'hC;
        rx_fs = 1'b1; rx_btype = bt; rx_bdata = bd;
        lat = 0;
        while (lat < 20 && rx_fd !== 1'b1) begin
            @(negedge clk);
            lat++;
        end
        rx_fs = 1'b0;
        @(negedge clk); // DEC
        @(negedge clk); // SEND
        n_tests++;
        if (tx_fs !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_send: got tx_fs=%b expected 1", tx_fs);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rx_fd !== 1'b0 || tx_fs !== 1'b0 || tx_btype !== 4'h0 || didx !== 4'h0
            || freq !== 4'h0 || ddidx !== 4'h0 || cfg_upd !== 1'b0 || err_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_in_send: got rx_fd=%b tx_fs=%b txb=%h didx=%h freq=%h ddidx=%h upd=%b err=%h expected all zero",
                     rx_fd, tx_fs, tx_btype, didx, freq, ddidx, cfg_upd, err_cnt);
        end
        rst = 1'b0;
        m_didx = '0; m_freq = '0; m_ddidx = '0; m_txb = '0; m_err = 0;
        // Operation resumes normally from IDLE.
        send_packet(4'b0110, 4'h7, 2, 1, 1'b0, 4'h0, 4'h0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_didx();
        test_dparam();
        test_no_reply();
        test_nak_types();
        test_pending();
        test_random();
        test_err_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
